// File: rtl/hm01b0_band_ingester.sv
// HM01B0 parallel camera capture: resamples the pixel bus into clock and scatters
// each 8-line band into a double-buffered bank of 8x8-block EBRs.
module hm01b0_band_ingester #(
    parameter int IMAGE_WIDTH = 320,
    parameter int NUM_EBRS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       hm01b0_pixclk,
    input  logic [7:0] hm01b0_pixdata,
    input  logic       hm01b0_hsync,
    input  logic       hm01b0_vsync,
    output logic [2:0] output_block_select,
    output logic       frontbuffer_select,
    output logic [8:0] output_write_addr,
    output logic [7:0] output_pixval,
    output logic       wren
);

    localparam logic [8:0] WIDTH_LIMIT = 9'(IMAGE_WIDTH);
    localparam logic [5:0] EBRS        = 6'(NUM_EBRS);

    logic [SYNC_STAGES-1:0] pixclk_sync;
    logic [SYNC_STAGES-1:0] hsync_sync;
    logic [SYNC_STAGES-1:0] vsync_sync;
    logic [7:0]             pixdata_sync [SYNC_STAGES];
    logic                   pixclk_prev;
    logic                   hsync_prev;
    logic                   vsync_prev;
    logic [SYNC_STAGES:0]   primed;
    logic                   frame_valid;
    logic [8:0]             col;
    logic [2:0]             row;

    logic       pixclk_s;
    logic       hsync_s;
    logic       vsync_s;
    logic [7:0] pixdata_s;
    logic       edges_ok;
    logic       pixel_event;
    logic       line_end;
    logic       vsync_rise;
    logic       vsync_fall;
    logic [5:0] block_idx;
    logic [2:0] block_row;
    logic [2:0] block_col;

    // Edge detection waits until the synchronizers hold real samples, so a vsync
    // already high when reset releases is not mistaken for a new frame.
    always_comb begin
        pixclk_s    = pixclk_sync[SYNC_STAGES-1];
        hsync_s     = hsync_sync[SYNC_STAGES-1];
        vsync_s     = vsync_sync[SYNC_STAGES-1];
        pixdata_s   = pixdata_sync[SYNC_STAGES-1];
        edges_ok    = primed[SYNC_STAGES];
        pixel_event = edges_ok && frame_valid && vsync_s && hsync_s && pixclk_s && !pixclk_prev;
        line_end    = edges_ok && frame_valid && vsync_s && !hsync_s && hsync_prev;
        vsync_rise  = edges_ok && vsync_s && !vsync_prev;
        vsync_fall  = edges_ok && !vsync_s && vsync_prev;
        block_idx   = col[8:3];
        block_row   = 3'(block_idx / EBRS);
        block_col   = 3'(block_idx % EBRS);
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            pixclk_sync         <= '0;
            hsync_sync          <= '0;
            vsync_sync          <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pixdata_sync[i] <= '0;
            end
            pixclk_prev         <= 1'b0;
            hsync_prev          <= 1'b0;
            vsync_prev          <= 1'b0;
            primed              <= '0;
            frame_valid         <= 1'b0;
            col                 <= '0;
            row                 <= '0;
            output_block_select <= '0;
            frontbuffer_select  <= 1'b0;
            output_write_addr   <= '0;
            output_pixval       <= '0;
            wren                <= 1'b0;
        end else begin
            pixclk_sync[0]  <= hm01b0_pixclk;
            hsync_sync[0]   <= hm01b0_hsync;
            vsync_sync[0]   <= hm01b0_vsync;
            pixdata_sync[0] <= hm01b0_pixdata;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pixclk_sync[i]  <= pixclk_sync[i-1];
                hsync_sync[i]   <= hsync_sync[i-1];
                vsync_sync[i]   <= vsync_sync[i-1];
                pixdata_sync[i] <= pixdata_sync[i-1];
            end
            pixclk_prev <= pixclk_s;
            hsync_prev  <= hsync_s;
            vsync_prev  <= vsync_s;
            primed      <= {primed[SYNC_STAGES-1:0], 1'b1};
            wren        <= 1'b0;

            if (vsync_rise) begin
                frame_valid <= 1'b1;
                col         <= '0;
                row         <= '0;
            end else if (vsync_fall) begin
                frame_valid <= 1'b0;
                col         <= '0;
                row         <= '0;
            end else if (pixel_event) begin
                // col parks at WIDTH_LIMIT so over-long lines drop the excess pixels
                if (col < WIDTH_LIMIT) begin
                    wren                <= 1'b1;
                    output_block_select <= block_col;
                    output_write_addr   <= {block_row, row, col[2:0]};
                    output_pixval       <= pixdata_s;
                    col                 <= col + 9'd1;
                end
            end else if (line_end) begin
                col <= '0;
                row <= row + 3'd1;
                if (row == 3'd7) begin
                    frontbuffer_select <= ~frontbuffer_select;
                end
            end
        end
    end

endmodule

// File: tb/tb_hm01b0_band_ingester.sv
// Directed bench for hm01b0_band_ingester: drives camera lines at clock/4 and
// checks every captured write against the expected block/address mapping.
module tb_hm01b0_band_ingester;

    logic       clock = 1'b0;
    logic       nreset;
    logic       hm01b0_pixclk;
    logic [7:0] hm01b0_pixdata;
    logic       hm01b0_hsync;
    logic       hm01b0_vsync;
    logic [2:0] output_block_select;
    logic       frontbuffer_select;
    logic [8:0] output_write_addr;
    logic [7:0] output_pixval;
    logic       wren;

    always #5 clock = ~clock;

    hm01b0_band_ingester dut (
        .clock               (clock),
        .nreset              (nreset),
        .hm01b0_pixclk       (hm01b0_pixclk),
        .hm01b0_pixdata      (hm01b0_pixdata),
        .hm01b0_hsync        (hm01b0_hsync),
        .hm01b0_vsync        (hm01b0_vsync),
        .output_block_select (output_block_select),
        .frontbuffer_select  (frontbuffer_select),
        .output_write_addr   (output_write_addr),
        .output_pixval       (output_pixval),
        .wren                (wren)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   q_sel[$];
    int   q_addr[$];
    int   q_val[$];
    int   q_fb[$];
    int   n_double = 0;
    int   n_clash  = 0;
    logic wren_prev = 1'b0;
    logic fb_prev   = 1'b0;

    logic [21:0] outs;
    assign outs = {output_block_select, frontbuffer_select, output_write_addr, output_pixval, wren};

    // write logger, sampled just after each active edge
    always @(posedge clock) begin
        #1;
        if (wren) begin
            q_sel.push_back(int'(output_block_select));
            q_addr.push_back(int'(output_write_addr));
            q_val.push_back(int'(output_pixval));
            q_fb.push_back(int'(frontbuffer_select));
        end
        if (wren && wren_prev) n_double++;
        if (wren && (frontbuffer_select !== fb_prev)) n_clash++;
        wren_prev = wren;
        fb_prev   = frontbuffer_select;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_sel.delete();
        q_addr.delete();
        q_val.delete();
        q_fb.delete();
    endtask

    task automatic send_pixel(input logic [7:0] d);
        @(negedge clock);
        hm01b0_pixclk  = 1'b0;
        hm01b0_pixdata = d;
        @(negedge clock);
        @(negedge clock);
        hm01b0_pixclk = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_line(input int n);
        @(negedge clock);
        hm01b0_hsync = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_pixel(i[7:0]);
        end
        @(negedge clock);
        hm01b0_hsync = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    // Writes of one line arrive in column order starting at col 0.
    task automatic verify_line(input string tag, input int row, input int exp_n, input int exp_fb);
        int bad = 0;
        check({tag, "_count"}, q_addr.size(), exp_n);
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_sel[i]  != (i / 8) % 5) bad++;
            if (q_addr[i] != ((i / 8) / 5) * 64 + row * 8 + i % 8) bad++;
            if (q_val[i]  != i % 256) bad++;
            if (q_fb[i]   != exp_fb) bad++;
        end
        check({tag, "_map"}, bad, 0);
    endtask

    task automatic check_write(input string tag, input int idx, input int sel, input int addr, input int val);
        if (idx < q_addr.size()) begin
            check({tag, "_sel"},  q_sel[idx],  sel);
            check({tag, "_addr"}, q_addr[idx], addr);
            check({tag, "_val"},  q_val[idx],  val);
        end else begin
            check({tag, "_present"}, q_addr.size(), idx + 1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset         = 1'b1;
        hm01b0_pixclk  = 1'b0;
        hm01b0_hsync   = 1'b0;
        hm01b0_vsync   = 1'b0;
        hm01b0_pixdata = 8'h00;
        repeat (5) @(negedge clock);
        check("reset_outs", outs, 0);
        nreset = 1'b0;
        repeat (100) @(negedge clock);
        check("idle_writes", q_addr.size(), 0);
        check("idle_outs", outs, 0);

        hm01b0_vsync = 1'b1;
        repeat (8) @(negedge clock);

        // band 0: eight full lines
        clear_log();
        send_line(320);
        verify_line("line0", 0, 320, 0);
        check_write("px0",   0,   0, 12'h000, 8'h00);
        check_write("px8",   8,   1, 12'h000, 8'h08);
        check_write("px40",  40,  0, 12'h040, 8'h28);
        check_write("px319", 319, 4, 12'h1C7, 8'h3F);
        for (int r = 1; r < 8; r++) begin
            clear_log();
            send_line(320);
            verify_line($sformatf("line%0d", r), r, 320, 0);
            if (r == 5) check_write("row5_col100", 100, 2, 12'h0AC, 100);
            if (r == 6) check("fb_before_wrap", frontbuffer_select, 0);
        end
        check("fb_band0_done", frontbuffer_select, 1);

        // band 1: short lines still advance row
        for (int r = 0; r < 8; r++) begin
            clear_log();
            send_line(16);
            verify_line($sformatf("band1_line%0d", r), r, 16, 1);
            if (r == 0) check_write("band1_px0", 0, 0, 12'h000, 8'h00);
            if (r == 1) check_write("band1_px9", 9, 1, 12'h009, 8'h09);
        end
        check("fb_band1_done", frontbuffer_select, 0);

        // over-long line is clipped, next line restarts at col 0
        clear_log();
        send_line(330);
        verify_line("long_line", 0, 320, 0);
        clear_log();
        send_line(8);
        verify_line("after_long", 1, 8, 0);
        check_write("after_long_px0", 0, 0, 12'h008, 8'h00);
        clear_log();
        send_line(8);
        verify_line("third_line", 2, 8, 0);

        // partial band discarded on vsync drop; hsync ignored while vsync low
        @(negedge clock);
        hm01b0_vsync = 1'b0;
        repeat (8) @(negedge clock);
        clear_log();
        send_line(8);
        check("no_vsync_writes", q_addr.size(), 0);
        hm01b0_vsync = 1'b1;
        repeat (8) @(negedge clock);
        clear_log();
        send_line(8);
        verify_line("new_frame", 0, 8, 0);
        check_write("new_frame_px0", 0, 0, 12'h000, 8'h00);
        check("fb_after_drop", frontbuffer_select, 0);
        for (int r = 1; r < 8; r++) begin
            clear_log();
            send_line(8);
            verify_line($sformatf("band2_line%0d", r), r, 8, 0);
        end
        check("fb_band2_done", frontbuffer_select, 1);

        // reset in the middle of a line, vsync held high throughout
        @(negedge clock);
        hm01b0_hsync = 1'b1;
        for (int i = 0; i < 4; i++) send_pixel(i[7:0]);
        nreset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("mid_reset_outs", outs, 0);
        repeat (3) @(negedge clock);
        nreset = 1'b0;
        clear_log();
        for (int i = 0; i < 10; i++) send_pixel(i[7:0]);
        @(negedge clock);
        hm01b0_hsync = 1'b0;
        repeat (10) @(negedge clock);
        send_line(8);
        check("no_write_before_vsync", q_addr.size(), 0);
        check("post_reset_outs", outs, 0);
        hm01b0_vsync = 1'b0;
        repeat (8) @(negedge clock);
        hm01b0_vsync = 1'b1;
        repeat (8) @(negedge clock);
        clear_log();
        send_line(8);
        verify_line("restart", 0, 8, 0);

        check("wren_width", n_double, 0);
        check("fb_vs_wren", n_clash, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
